// File: rtl/fifo_read_stream_adapter.sv
// Read-domain adapter behind an async FIFO: issues pops from the empty flag, captures the
// registered read data into a 2-entry buffer and presents it as a valid/ready stream.
module fifo_read_stream_adapter #(
    parameter int BITSIZE    = 8,
    parameter int COUNTWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [BITSIZE-1:0]    fifo_rdata,
    output logic                  fifo_r_enable,
    output logic [BITSIZE-1:0]    out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [COUNTWIDTH-1:0] word_count,
    output logic                  busy
);

    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  drop_q, drop_d;
    logic [BITSIZE-1:0]    buf0_q, buf0_d;
    logic [BITSIZE-1:0]    buf1_q, buf1_d;
    logic [COUNTWIDTH-1:0] wc_q, wc_d;
    logic                  out_valid_q, out_valid_d;

    logic       fire;
    logic       capture;
    logic [2:0] commit;
    logic [1:0] tail;

    always_comb begin
        fire    = out_valid_q & out_ready;
        // slots already spoken for once this cycle's fire has left the buffer
        commit  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, fire};
        fifo_r_enable = ~reset & ~flush & ~fifo_empty & (commit < 3'd2);
        capture = inflight_q & ~drop_q & ~flush;
        tail    = count_q - {1'b0, fire};

        count_d     = count_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        wc_d        = wc_q;
        inflight_d  = fifo_r_enable;
        drop_d      = flush & inflight_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (fire) begin
                wc_d = wc_q + {{(COUNTWIDTH-1){1'b0}}, 1'b1};
                if (count_q == 2'd2) begin
                    buf0_d = buf1_q;
                end
            end
            if (capture) begin
                if (tail == 2'd0) begin
                    buf0_d = fifo_rdata;
                end else begin
                    buf1_d = fifo_rdata;
                end
            end
            count_d = count_q - {1'b0, fire} + {1'b0, capture};
        end

        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            drop_q      <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            wc_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            wc_q        <= wc_d;
            out_valid_q <= out_valid_d;
        end
    end

    // head of the buffer stays put when it empties, so out_data keeps the last word
    assign out_data   = buf0_q;
    assign out_valid  = out_valid_q;
    assign word_count = wc_q;
    assign busy       = (count_q != 2'd0) | inflight_q;

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Bench for fifo_read_stream_adapter: queue-based FIFO model and a queue-level reference
// of the buffer, directed phases with randomized data, two counter widths in parallel.
module tb_fifo_read_stream_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, fifo_empty, out_ready, flush;
    logic [7:0]  fifo_rdata;
    logic        fifo_r_enable, out_valid, busy;
    logic [7:0]  out_data;
    logic [15:0] word_count;
    logic        r_en4, out_valid4, busy4;
    logic [7:0]  out_data4;
    logic [3:0]  word_count4;

    fifo_read_stream_adapter #(.BITSIZE(8), .COUNTWIDTH(16)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_r_enable(fifo_r_enable), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .word_count(word_count), .busy(busy));

    fifo_read_stream_adapter #(.BITSIZE(8), .COUNTWIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_r_enable(r_en4), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .flush(flush), .word_count(word_count4), .busy(busy4));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] rdata_next;
    logic [7:0] ref_buf[$];
    bit         m_inflight;
    logic [7:0] m_last;
    int         m_wc;

    logic [7:0] delivered[$];
    int         fire_cyc[$];
    logic [7:0] exp_words[$];
    int         first_valid;
    int         pops;
    logic       obs_valid, obs_ren, obs_busy;
    logic [7:0] obs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic       exp_valid, fire_m, exp_pop, exp_busy;
        logic [7:0] exp_data;
        int         occ;
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = rdata_next;
        @(negedge clk);
        occ       = ref_buf.size();
        exp_valid = (occ != 0);
        fire_m    = exp_valid && out_ready;
        exp_pop   = !reset && !flush && !fifo_empty &&
                    (occ + int'(m_inflight) - int'(fire_m) < 2);
        if (exp_valid) exp_data = ref_buf[0];
        else           exp_data = m_last;
        exp_busy  = exp_valid || m_inflight;

        chk("r_enable",  {31'd0, fifo_r_enable}, {31'd0, exp_pop});
        chk("out_valid", {31'd0, out_valid},     {31'd0, exp_valid});
        chk("out_data",  {24'd0, out_data},      {24'd0, exp_data});
        chk("busy",      {31'd0, busy},          {31'd0, exp_busy});
        chk("wc16",      {16'd0, word_count},    m_wc % 65536);
        chk("wc4",       {28'd0, word_count4},   m_wc % 16);
        chk("r_enable4", {31'd0, r_en4},         {31'd0, exp_pop});

        obs_valid = out_valid;
        obs_ren   = fifo_r_enable;
        obs_busy  = busy;
        obs_data  = out_data;
        if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (out_valid === 1'b1 && out_ready && !flush && !reset) begin
            delivered.push_back(out_data);
            fire_cyc.push_back(cyc);
        end
        if (fifo_r_enable === 1'b1) pops++;

        if (fifo_r_enable === 1'b1 && fifo_q.size() > 0) rdata_next = fifo_q.pop_front();
        else                                             rdata_next = 8'($urandom);

        if (reset) begin
            ref_buf.delete();
            m_inflight = 1'b0;
            m_last     = 8'h00;
            m_wc       = 0;
        end else if (flush) begin
            ref_buf.delete();
            m_inflight = 1'b0;
        end else begin
            if (fire_m) begin
                void'(ref_buf.pop_front());
                m_wc++;
            end
            if (m_inflight) ref_buf.push_back(fifo_rdata);
            m_inflight = exp_pop;
        end
        if (ref_buf.size() > 0) m_last = ref_buf[0];
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (delivered.size() < n && k < budget) begin
            cycle();
            k++;
        end
        if (delivered.size() < n) chk(tag, delivered.size(), n);
    endtask

    task automatic clear_logs();
        delivered.delete();
        fire_cyc.delete();
        exp_words.delete();
        first_valid = -1;
        pops = 0;
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_words.push_back(w);
    endtask

    task automatic check_seq(input string tag, input bit gapless);
        for (int i = 0; i < exp_words.size(); i++) begin
            if (i < delivered.size()) chk(tag, {24'd0, delivered[i]}, {24'd0, exp_words[i]});
        end
        chk({tag, "_count"}, delivered.size(), exp_words.size());
        if (gapless) begin
            for (int i = 1; i < fire_cyc.size(); i++)
                chk({tag, "_gap"}, fire_cyc[i] - fire_cyc[i-1], 1);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        fifo_empty = 1'b1; fifo_rdata = 8'h00; rdata_next = 8'h00;
        ref_buf.delete(); m_inflight = 1'b0; m_last = 8'h00; m_wc = 0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // idle after reset
        repeat (10) cycle();
        chk("t1_ren",   {31'd0, obs_ren},   0);
        chk("t1_valid", {31'd0, obs_valid}, 0);
        chk("t1_data",  {24'd0, obs_data},  0);
        chk("t1_busy",  {31'd0, obs_busy},  0);
        chk("t1_wc",    {16'd0, word_count}, 0);

        // latency and back-to-back delivery
        clear_logs();
        out_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        begin
            int n0;
            n0 = cyc;
            run_until(3, 20, "t2_timeout");
            chk("t2_first_valid", first_valid, n0 + 2);
        end
        check_seq("t2_seq", 1'b1);
        chk("t2_wc", {16'd0, word_count}, 3);
        repeat (3) cycle();

        // backpressure
        clear_logs();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(8'(i * 16 + i));
        repeat (6) cycle();
        chk("t3_pops", pops, 2);
        chk("t3_hold", {24'd0, obs_data}, 8'h11);
        out_ready = 1'b1;
        run_until(8, 30, "t3_timeout");
        check_seq("t3_seq", 1'b1);
        chk("t3_wc", {16'd0, word_count}, 11);
        repeat (3) cycle();

        // toggling ready; 16-bit count reaches 16, 4-bit count wraps to 0
        clear_logs();
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        begin
            int k;
            k = 0;
            while (delivered.size() < 5 && k < 40) begin
                out_ready = (k % 2 == 0);
                cycle();
                k++;
            end
            if (delivered.size() < 5) chk("t4_timeout", delivered.size(), 5);
        end
        check_seq("t4_seq", 1'b0);
        chk("t4_wc16", {16'd0, word_count}, 16);
        chk("t4_wc4",  {28'd0, word_count4}, 0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // flush with a word in flight and a coincident fire
        clear_logs();
        out_ready = 1'b0;
        fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2);
        fifo_q.push_back(8'hA3); fifo_q.push_back(8'hA4);
        cycle();
        cycle();
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0; out_ready = 1'b0;
        cycle();
        chk("t5_valid_after_flush", {31'd0, obs_valid}, 0);
        chk("t5_wc_unchanged", {16'd0, word_count}, 16);
        clear_logs();
        exp_words.push_back(8'hA3); exp_words.push_back(8'hA4);
        out_ready = 1'b1;
        run_until(2, 20, "t5_timeout");
        check_seq("t5_seq", 1'b0);
        chk("t5_wc", {16'd0, word_count}, 18);
        repeat (3) cycle();

        // fresh count, 18 words: 4-bit counter wraps to 2
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < 18; i++) push_word(8'($urandom));
        run_until(18, 60, "t6_timeout");
        check_seq("t6_seq", 1'b1);
        chk("t6_wc4",  {28'd0, word_count4}, 2);
        chk("t6_wc16", {16'd0, word_count},  18);

        // reset mid-stream
        clear_logs();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'($urandom));
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        chk("t6_rst_no_pop", {31'd0, obs_ren}, 0);
        reset = 1'b0;
        cycle();
        chk("t6_post_valid", {31'd0, obs_valid}, 0);
        chk("t6_post_data",  {24'd0, obs_data},  0);
        chk("t6_post_wc",    {16'd0, word_count}, 0);
        repeat (20) cycle();
        chk("t6_drained_busy", {31'd0, obs_busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
